udp_ingress_fifo: RTL
=====================

UDP_INGRESS_FIFO -- requirements
Module: udp_ingress_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter PKT_BEATS, default 63, beats per UDP packet.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 In_data  input  256  upstream beat.
REQ-006 In_valid  input  1  upstream beat valid.
REQ-007 In_ready  output  1  block can accept a beat.
REQ-008 Out_data  output  256  beat to the parser.
REQ-009 Out_valid  output  1  Out_data holds a beat.
REQ-010 Out_ready  input  1  parser accepts the beat.
REQ-011 Fill_level  output  $clog2(DEPTH)+1  entries currently held.
REQ-012 Pkt_done  output  1  one-cycle pulse when the last beat of a packet is accepted at the input.
REQ-013 Bad_op  output  1  one-cycle pulse when beat 1 is accepted with an opcode other than 1 or 2.

Function
REQ-014 An input beat SHALL be accepted when In_valid and In_ready are both 1 on a rising edge.
REQ-015 An output beat SHALL be consumed when Out_valid and Out_ready are both 1 on a rising edge.
REQ-016 In_ready SHALL equal (Fill_level != DEPTH), driven from registered state only.
REQ-017 Out_valid SHALL equal (Fill_level != 0), and Out_data SHALL present the oldest entry (first-word-fall-through).
REQ-018 Latency from input accept to Out_valid SHALL be exactly 1 cycle; there is no same-cycle bypass.
REQ-019 Beat order SHALL be preserved, and data SHALL pass unmodified.
REQ-020 Simultaneous accept and consume SHALL leave Fill_level unchanged.
REQ-021 When full, a beat offered on In_valid SHALL NOT be written, and the upstream holds it.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 An input beat index counter SHALL count 0..PKT_BEATS-1: increment on each accept, wrap to 0 after index PKT_BEATS-1.
REQ-024 Pkt_done SHALL pulse in the cycle after the accept of index PKT_BEATS-1.
REQ-025 Bad_op SHALL pulse in the cycle after the accept of index 1 when In_data[175:160] is not 1 and not 2.
REQ-026 A flagged packet SHALL still be forwarded in full; dropping packets is not this block's job.
REQ-027 Pkt_done and Bad_op SHALL be registered outputs, 0 when no event occurs.

Reset
REQ-028 Reset assertion SHALL asynchronously clear pointers, Fill_level, the beat index, Pkt_done and Bad_op; In_ready SHALL be 1 and Out_valid 0.
REQ-029 Storage contents need not be reset; Out_data is don't-care while Out_valid is 0.
REQ-030 A reset in mid-packet SHALL discard all buffered beats, and the next accepted beat SHALL be index 0.

Configuration
REQ-031 With macro UDP_INGRESS_PKT_STATS_EN defined, the block SHALL add output Pkt_count (16 bits).
REQ-032 Pkt_count SHALL increment on each Pkt_done, wrap from 65535 to 0, and reset to 0.
REQ-033 With UDP_INGRESS_PKT_STATS_EN undefined, the Pkt_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package udp_pkg SHALL hold UDP_BEAT_W=256, UDP_PKT_BEATS=63, UDP_OPCODE_LSB=160, UDP_OPCODE_W=16, UDP_OP_SUM=1 and UDP_OP_MAX=2.
REQ-035 Storage SHALL be the sub-module udp_fifo_mem: DEPTH x 256 with one write port and an asynchronous read port.
REQ-036 Pointer, count and beat-index logic SHALL reside in udp_ingress_fifo.

Verification
REQ-037 Reset release, Out_ready=1, one beat In_data=0xA5 -> Out_valid=1 one cycle later with Out_data=0xA5, and Fill_level returns to 0.
REQ-038 Out_ready=0 with 10 beats offered -> 8 accepted, In_ready=0, Fill_level=8; then Out_ready=1 -> beats 0..7 exit in order, and the held 9th beat is accepted.
REQ-039 Full FIFO with In_valid=1 and Out_ready=1 on the same edge -> one beat out, none in that cycle, and Fill_level=7 with In_ready=1 on the next cycle.
REQ-040 Two 63-beat packets with opcodes 1 then 5 in [175:160] of beat 1 -> Pkt_done pulses twice, Bad_op pulses once (second packet), and Pkt_count=2 when stats are enabled.
REQ-041 Reset asserted after beat 30 with 5 beats buffered -> Out_valid=0 and Fill_level=0 immediately; a following 63-beat packet produces exactly one Pkt_done on its last beat.

Source files
------------

// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and helpers for the UDP ingress path.
//   UDP_BEAT_W     - width of one upstream beat
//   UDP_PKT_BEATS  - beats per UDP packet
//   UDP_OPCODE_*   - location/width of the opcode field carried in beat 1
//   UDP_OP_SUM/MAX - the only opcodes the parser understands
package udp_pkg;

  localparam int unsigned UDP_BEAT_W     = 256;
  localparam int unsigned UDP_PKT_BEATS  = 63;
  localparam int unsigned UDP_OPCODE_LSB = 160;
  localparam int unsigned UDP_OPCODE_W   = 16;
  localparam int unsigned UDP_OP_SUM     = 1;
  localparam int unsigned UDP_OP_MAX     = 2;

  typedef logic [UDP_BEAT_W-1:0]   udp_beat_t;
  typedef logic [UDP_OPCODE_W-1:0] udp_opcode_t;

  // True for opcodes the downstream parser knows how to handle.
  function automatic logic udp_op_known(input udp_opcode_t op);
    return (op == UDP_OPCODE_W'(UDP_OP_SUM)) || (op == UDP_OPCODE_W'(UDP_OP_MAX));
  endfunction

endpackage

// File: rtl/udp_fifo_mem.sv
// udp_fifo_mem: DEPTH x WIDTH storage array, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset.
//   clk        - write clock
//   i_wr_en    - write enable
//   i_wr_addr  - write address
//   i_wr_data  - write data
//   i_rd_addr  - read address
//   o_rd_data  - data at i_rd_addr, available in the same cycle
module udp_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/udp_ingress_fifo.sv
// udp_ingress_fifo: first-word-fall-through buffer between the UDP beat
// source and the parser. Tracks the beat index inside each packet, pulses
// Pkt_done on the last beat and Bad_op when beat 1 carries an unknown opcode.
// Flagged packets are still forwarded unchanged.
//   clk, reset   - clock, asynchronous active-low reset
//   In_data/In_valid/In_ready    - upstream beat handshake
//   Out_data/Out_valid/Out_ready - downstream beat handshake
//   Fill_level   - entries currently held
//   Pkt_done     - registered pulse after last beat of a packet is accepted
//   Bad_op       - registered pulse after beat 1 with unknown opcode is accepted
//   Pkt_count    - completed packet counter (only with UDP_INGRESS_PKT_STATS_EN)
module udp_ingress_fifo
  import udp_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PKT_BEATS = UDP_PKT_BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [UDP_BEAT_W-1:0]   In_data,
  input  logic                    In_valid,
  output logic                    In_ready,
  output logic [UDP_BEAT_W-1:0]   Out_data,
  output logic                    Out_valid,
  input  logic                    Out_ready,
  output logic [$clog2(DEPTH):0]  Fill_level,
  output logic                    Pkt_done,
  output logic                    Bad_op
`ifdef UDP_INGRESS_PKT_STATS_EN
  ,
  output logic [15:0]             Pkt_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_fill;
  logic [IW-1:0] r_idx;
  logic          r_pkt_done;
  logic          r_bad_op;

  logic          w_wr;
  logic          w_rd;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_last_beat;
  logic          w_bad_beat;
  logic [AW:0]   w_fill_d;

  // Flow control comes only from the registered fill count, so a read on the
  // same edge never frees a slot for a write while full.
  assign w_in_ready  = (r_fill != (AW + 1)'(DEPTH));
  assign w_out_valid = (r_fill != '0);
  assign w_wr        = In_valid && w_in_ready;
  assign w_rd        = w_out_valid && Out_ready;

  assign w_last_beat = w_wr && (r_idx == IW'(PKT_BEATS - 1));
  assign w_bad_beat  = w_wr && (r_idx == IW'(1)) &&
                       !udp_op_known(In_data[UDP_OPCODE_LSB +: UDP_OPCODE_W]);

  always_comb begin
    w_fill_d = r_fill;
    unique case ({w_wr, w_rd})
      2'b10:   w_fill_d = r_fill + (AW + 1)'(1);
      2'b01:   w_fill_d = r_fill - (AW + 1)'(1);
      default: w_fill_d = r_fill;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_idx      <= '0;
      r_pkt_done <= 1'b0;
      r_bad_op   <= 1'b0;
    end else begin
      r_fill     <= w_fill_d;
      r_pkt_done <= w_last_beat;
      r_bad_op   <= w_bad_beat;
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
        r_idx  <= w_last_beat ? '0 : r_idx + IW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

`ifdef UDP_INGRESS_PKT_STATS_EN
  logic [15:0] r_pkt_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_count <= '0;
    end else if (w_last_beat) begin
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign Pkt_count = r_pkt_count;
`endif

  udp_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UDP_BEAT_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr),
    .i_wr_data (In_data),
    .i_rd_addr (r_rptr),
    .o_rd_data (Out_data)
  );

  assign In_ready   = w_in_ready;
  assign Out_valid  = w_out_valid;
  assign Fill_level = r_fill;
  assign Pkt_done   = r_pkt_done;
  assign Bad_op     = r_bad_op;

endmodule
